// File: rtl/uart_hex_fmt.sv
// Formats one WORD_WIDTH-bit word per input handshake as an ASCII hex line (MSB nibble first) ending in CR LF.
// Define HEX_FMT_PREFIX_EN to start every line with "0x".
module uart_hex_fmt #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter bit          UPPERCASE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy
);
    localparam int unsigned      NIBBLES    = WORD_WIDTH / 4;
    localparam int unsigned      IDX_W      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NIBBLES - 1);
    localparam logic [7:0]       CHAR_CR    = 8'h0D;
    localparam logic [7:0]       CHAR_LF    = 8'h0A;
    localparam logic [7:0]       ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

    // State names the character currently held in m_axis_tdata.
    typedef enum logic [2:0] {
        IDLE,
`ifdef HEX_FMT_PREFIX_EN
        PFX0,
        PFX1,
`endif
        DIGIT,
        CR,
        LF
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [WORD_WIDTH-1:0]   word;
    logic                    consume;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) hex_char = 8'h30 + 8'(n);
        else           hex_char = ALPHA_BASE + 8'(n - 4'd10);
    endfunction

    function automatic logic [3:0] nibble(input logic [WORD_WIDTH-1:0] w, input logic [IDX_W-1:0] i);
        nibble = 4'(w >> {i, 2'b00});
    endfunction

    assign s_axis_tready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign consume       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            word          <= '0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        word          <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
`ifdef HEX_FMT_PREFIX_EN
                        m_axis_tdata  <= 8'h30;
                        state         <= PFX0;
`else
                        m_axis_tdata  <= hex_char(nibble(s_axis_tdata, IDX_TOP));
                        idx           <= IDX_TOP;
                        state         <= DIGIT;
`endif
                    end
                end
`ifdef HEX_FMT_PREFIX_EN
                PFX0: begin
                    if (consume) begin
                        m_axis_tdata <= 8'h78;
                        state        <= PFX1;
                    end
                end
                PFX1: begin
                    if (consume) begin
                        m_axis_tdata <= hex_char(nibble(word, IDX_TOP));
                        idx          <= IDX_TOP;
                        state        <= DIGIT;
                    end
                end
`endif
                DIGIT: begin
                    if (consume) begin
                        if (idx == '0) begin
                            m_axis_tdata <= CHAR_CR;
                            state        <= CR;
                        end else begin
                            idx          <= idx - IDX_W'(1);
                            m_axis_tdata <= hex_char(nibble(word, idx - IDX_W'(1)));
                        end
                    end
                end
                CR: begin
                    if (consume) begin
                        m_axis_tdata <= CHAR_LF;
                        state        <= LF;
                    end
                end
                LF: begin
                    if (consume) begin
                        m_axis_tvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
